// File: rtl/q_argmax_if.sv
// Handshake and RAM read-port bundle between the policy FSM, the argmax reader
// and the action/Q-value RAM.
interface q_argmax_if #(
   parameter int STATE_W = 4,
   parameter int ACT_W   = 2,
   parameter int DATA_W  = 16
);
   localparam int ADDR_W = STATE_W + ACT_W;

   logic                     start;
   logic [STATE_W-1:0]       state_in;
   logic                     busy;
   logic                     done;
   logic [ACT_W-1:0]         best_act;
   logic signed [DATA_W-1:0] best_q;
   logic                     explore;
   logic                     ram_en;
   logic [ADDR_W-1:0]        ram_rd_addr;
   logic signed [DATA_W-1:0] ram_data;

   modport slave (
      input  start, state_in, ram_data,
      output busy, done, best_act, best_q, explore, ram_en, ram_rd_addr
   );

   modport master (
      output start, state_in, ram_data,
      input  busy, done, best_act, best_q, explore, ram_en, ram_rd_addr
   );
endinterface

// File: rtl/q_argmax_reader.sv
// Scans one state row of the Q-value RAM and reports the action with the largest
// signed Q-value. Optional epsilon-greedy selection under macro EPS_GREEDY_EN.
module q_argmax_reader #(
   parameter int         STATE_W    = 4,
   parameter int         ACT_W      = 2,
   parameter int         DATA_W     = 16,
   parameter logic [7:0] EPS_THRESH = 8'd26
) (
   input logic     clk,
   input logic     rst,
   q_argmax_if.slave bus
);
   localparam int NUM_ACT = 2 ** ACT_W;

   typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

   state_t                   state_q;
   logic [ACT_W:0]           cnt;
   logic [STATE_W-1:0]       row_q;
   logic                     vld_p0, vld_p1;
   logic [ACT_W-1:0]         act_p0, act_p1;
   logic signed [DATA_W-1:0] run_q;
   logic [ACT_W-1:0]         run_act;
   logic                     accept, issue, last_cmp;

   function automatic logic q_gt(input logic signed [DATA_W-1:0] a,
                                 input logic signed [DATA_W-1:0] b);
      return a > b;
   endfunction

   assign accept   = (state_q == IDLE) && bus.start;
   assign issue    = (state_q == SCAN) && (cnt < (ACT_W+1)'(NUM_ACT));
   assign last_cmp = vld_p1 && (act_p1 == ACT_W'(NUM_ACT - 1));

`ifdef EPS_GREEDY_EN
   logic [15:0] lfsr;
`else
   logic unused_eps;
   assign unused_eps = ^EPS_THRESH;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         cnt             <= '0;
         vld_p0          <= 1'b0;
         vld_p1          <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.best_act    <= '0;
         bus.best_q      <= '0;
         bus.explore     <= 1'b0;
         bus.ram_en      <= 1'b0;
         bus.ram_rd_addr <= '0;
`ifdef EPS_GREEDY_EN
         lfsr            <= 16'hACE1;
`endif
      end else begin
`ifdef EPS_GREEDY_EN
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
         // p0: address issued this edge; p1: RAM registering it; compare one edge later
         vld_p0   <= accept || issue;
         vld_p1   <= vld_p0;
         bus.done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  bus.ram_en      <= 1'b1;
                  bus.ram_rd_addr <= {bus.state_in, {ACT_W{1'b0}}};
                  bus.busy        <= 1'b1;
                  cnt             <= (ACT_W+1)'(1);
                  state_q         <= SCAN;
               end
            end
            SCAN: begin
               if (issue) begin
                  bus.ram_rd_addr <= {row_q, cnt[ACT_W-1:0]};
                  cnt             <= cnt + 1'b1;
               end else begin
                  bus.ram_en <= 1'b0;
               end
               if (last_cmp) state_q <= FINISH;
            end
            FINISH: begin
               bus.best_q <= run_q;
               bus.done   <= 1'b1;
               bus.busy   <= 1'b0;
               state_q    <= IDLE;
`ifdef EPS_GREEDY_EN
               if (lfsr[7:0] < EPS_THRESH) begin
                  bus.best_act <= lfsr[8 +: ACT_W];
                  bus.explore  <= 1'b1;
               end else begin
                  bus.best_act <= run_act;
                  bus.explore  <= 1'b0;
               end
`else
               bus.best_act <= run_act;
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Datapath: row latch, action tags and running max; qualified by the valids above
   always_ff @(posedge clk) begin
      if (accept && !rst) row_q <= bus.state_in;
      act_p0 <= (state_q == IDLE) ? '0 : cnt[ACT_W-1:0];
      act_p1 <= act_p0;
      if (vld_p1 && ((act_p1 == '0) || q_gt(bus.ram_data, run_q))) begin
         run_q   <= bus.ram_data;
         run_act <= act_p1;
      end
   end
endmodule

// File: tb/tb_q_argmax_reader.sv
// Scoreboard bench for q_argmax_reader with a registered-read RAM model.
module tb_q_argmax_reader;
   localparam int         STATE_W = 4;
   localparam int         ACT_W   = 2;
   localparam int         DATA_W  = 16;
   localparam logic [7:0] TB_EPS  = 8'd255;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   q_argmax_if #(.STATE_W(STATE_W), .ACT_W(ACT_W), .DATA_W(DATA_W)) bus();

   q_argmax_reader #(.STATE_W(STATE_W), .ACT_W(ACT_W), .DATA_W(DATA_W),
                     .EPS_THRESH(TB_EPS)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic signed [15:0] mem [64];
   always @(posedge clk) bus.ram_data <= bus.ram_en ? mem[bus.ram_rd_addr] : 16'sd0;

   logic [15:0] m_lfsr, m_prev;
   always @(posedge clk) begin
      m_prev <= m_lfsr;
      m_lfsr <= rst ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   typedef struct {
      logic [1:0]  act;
      logic [15:0] q;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.state_in = '0;
      tick;
      tick;
      rst = 1'b0;
      total++;
      if ({bus.busy, bus.done, bus.explore, bus.ram_en} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_ctrl: got busy/done/explore/en=%b want 0000",
                  {bus.busy, bus.done, bus.explore, bus.ram_en});
      end
      total++;
      if (bus.ram_rd_addr !== 6'd0 || bus.best_act !== 2'd0 || bus.best_q !== 16'd0) begin
         bad++;
         $display("FAIL reset_data: got addr=%0d act=%0d q=%h want 0 0 0000",
                  bus.ram_rd_addr, bus.best_act, bus.best_q);
      end
   endtask

   // extra=1 also pulses start at E2 and E6 (the done edge); both must be ignored
   task automatic run_scan(input string name, input int s, input logic [1:0] ga,
                           input logic [15:0] gq, input bit extra);
      exp_t e;
      int lat;
      logic exp_ex;
      logic [1:0] exp_a;
      e.act = ga;
      e.q = gq;
      sb.push_back(e);
      bus.state_in = 4'(s);
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      bus.state_in = 4'(~s);
      total++;
      if (bus.busy !== 1'b1 || bus.ram_en !== 1'b1 || bus.ram_rd_addr !== 6'(s * 4)) begin
         bad++;
         $display("FAIL %s accept: got busy=%b en=%b addr=%0d want 1 1 %0d",
                  name, bus.busy, bus.ram_en, bus.ram_rd_addr, 6'(s * 4));
      end
      lat = 0;
      while (bus.done !== 1'b1 && lat < 20) begin
         bus.start = extra && (lat == 1 || lat == 5);
         tick;
         lat++;
         if (lat <= 3) begin
            total++;
            if (bus.ram_en !== 1'b1 || bus.ram_rd_addr !== 6'(s * 4 + lat)) begin
               bad++;
               $display("FAIL %s addr%0d: got en=%b addr=%0d want 1 %0d",
                        name, lat, bus.ram_en, bus.ram_rd_addr, 6'(s * 4 + lat));
            end
         end else if (lat == 4) begin
            total++;
            if (bus.ram_en !== 1'b0 || bus.ram_rd_addr !== 6'(s * 4 + 3)) begin
               bad++;
               $display("FAIL %s en_off: got en=%b addr=%0d want 0 %0d",
                        name, bus.ram_en, bus.ram_rd_addr, 6'(s * 4 + 3));
            end
         end
      end
      bus.start = 1'b0;
      total++;
      if (lat != 6) begin
         bad++;
         $display("FAIL %s latency: got %0d want 6", name, lat);
      end
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s scoreboard: got empty queue want one entry", name);
      end else begin
         e = sb.pop_front();
         exp_ex = 1'b0;
         exp_a = e.act;
`ifdef EPS_GREEDY_EN
         exp_ex = (m_prev[7:0] < TB_EPS);
         if (exp_ex) exp_a = m_prev[9:8];
`endif
         if (bus.best_act !== exp_a || bus.best_q !== e.q || bus.explore !== exp_ex) begin
            bad++;
            $display("FAIL %s result: got act=%0d q=%h explore=%b want %0d %h %b",
                     name, bus.best_act, bus.best_q, bus.explore, exp_a, e.q, exp_ex);
         end
      end
      total++;
      if (bus.busy !== 1'b0 || bus.ram_en !== 1'b0) begin
         bad++;
         $display("FAIL %s done_idle: got busy=%b en=%b want 0 0", name, bus.busy, bus.ram_en);
      end
      if (!extra) begin
         tick;
         total++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s pulse: got done=%b busy=%b want 0 0", name, bus.done, bus.busy);
         end
      end
   endtask

   task automatic test_greedy_rows;
      run_scan("row2", 2, 2'd2, 16'd12, 1'b0);
      run_scan("row0_neg_tie", 0, 2'd1, 16'hFFFE, 1'b0);
      run_scan("row15_edge", 15, 2'd3, 16'h7FFF, 1'b0);
   endtask

   task automatic test_back_to_back;
      run_scan("start_ignored", 2, 2'd2, 16'd12, 1'b1);
      run_scan("reaccept", 0, 2'd1, 16'hFFFE, 1'b0);
   endtask

   task automatic test_mid_reset;
      int dones;
      bus.state_in = 4'd2;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      total++;
      if ({bus.busy, bus.done, bus.ram_en} !== 3'b000 || bus.best_q !== 16'd0 || bus.best_act !== 2'd0) begin
         bad++;
         $display("FAIL mid_reset: got busy/done/en=%b act=%0d q=%h want 000 0 0000",
                  {bus.busy, bus.done, bus.ram_en}, bus.best_act, bus.best_q);
      end
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (bus.done === 1'b1) dones++;
      end
      total++;
      if (dones != 0) begin
         bad++;
         $display("FAIL mid_reset_nodone: got %0d done pulses want 0", dones);
      end
      run_scan("after_reset", 2, 2'd2, 16'd12, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'sd0;
      mem[8]  = 16'sd5;
      mem[9]  = -16'sd3;
      mem[10] = 16'sd12;
      mem[11] = 16'sd7;
      mem[0]  = -16'sd8;
      mem[1]  = -16'sd2;
      mem[2]  = -16'sd2;
      mem[3]  = -16'sd20;
      mem[63] = 16'sh7FFF;
      mem[4]  = 16'sh7FFF;
      test_reset;
      test_greedy_rows;
      test_back_to_back;
      test_mid_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
